// File: rtl/irq_ctrl_6502_pkg.sv
// Register map and helpers shared by the 6502 interrupt controller.
// Offsets follow CPU_AB[2:0] within the controller's I/O page slot.
package irq_ctrl_6502_pkg;

  localparam logic [2:0] IRQC_PEND   = 3'd0;
  localparam logic [2:0] IRQC_ENABLE = 3'd1;
  localparam logic [2:0] IRQC_EDGE   = 3'd2;
  localparam logic [2:0] IRQC_VECTOR = 3'd3;
  localparam logic [2:0] IRQC_RAW    = 3'd4;
  localparam logic [2:0] IRQC_NMISEL = 3'd5;

  localparam int VECTOR_ANY = 7;

  // Lowest-numbered active source wins; no active source yields 8'h00.
  function automatic logic [7:0] irqc_vector(input logic [7:0] act);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      if (act[i]) begin
        v             = 8'h00;
        v[VECTOR_ANY] = 1'b1;
        v[2:0]        = 3'(i);
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/irq_ctrl_6502_sync_edge.sv
// Per-source input synchronizer plus falling-edge (assertion) detector.
// Flops reset to 1 so a source held low through reset still produces an edge afterwards.
module irq_ctrl_6502_sync_edge #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic src_n_i,
  output logic level_o,
  output logic fall_o
);

  logic [SYNC_STG-1:0] sync_q, sync_d;
  logic                hist_q;

  assign sync_d = {sync_q[SYNC_STG-2:0], src_n_i};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      hist_q <= sync_q[SYNC_STG-1];
    end
  end

  assign level_o = ~sync_q[SYNC_STG-1];
  assign fall_o  = hist_q & ~sync_q[SYNC_STG-1];

endmodule

// File: rtl/irq_ctrl_6502.sv
// Memory-mapped IRQ merger for the 6502 I/O page: enable, edge/level mode, priority vector.
// Optional NMI routing register is built only when IRQC_NMI_EN is defined.
module irq_ctrl_6502
  import irq_ctrl_6502_pkg::*;
#(
  parameter int N_SRC    = 8,
  parameter int SYNC_STG = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cs_n,
  input  logic             we_n,
  input  logic [2:0]       rs,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  input  logic [N_SRC-1:0] src_irq_n,
  output logic             irq_n,
  output logic             nmi_n
);

  localparam logic [7:0] SRC_MASK = 8'((16'd1 << N_SRC) - 16'd1);

  logic [7:0] level_v, fall_v, nmisel;
  logic [7:0] pend_q, pend_d, enable_q, enable_d, edge_q, edge_d;
  logic [7:0] dout_q, dout_d, w1c, active, rdata;
  logic       irq_n_q, irq_n_d, nmi_n_q, nmi_n_d;
  logic       wr_en, rd_en;

  assign wr_en = !cs_n && !we_n;
  assign rd_en = !cs_n && we_n;

  for (genvar i = 0; i < 8; i++) begin : g_src
    if (i < N_SRC) begin : g_on
      irq_ctrl_6502_sync_edge #(
        .SYNC_STG(SYNC_STG)
      ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .src_n_i(src_irq_n[i]),
        .level_o(level_v[i]),
        .fall_o (fall_v[i])
      );
    end else begin : g_off
      assign level_v[i] = 1'b0;
      assign fall_v[i]  = 1'b0;
    end
  end

`ifdef IRQC_NMI_EN
  logic [7:0] nmisel_q, nmisel_d;

  always_comb begin
    nmisel_d = nmisel_q;
    if (wr_en && rs == IRQC_NMISEL) nmisel_d = din & SRC_MASK;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) nmisel_q <= 8'h00;
    else          nmisel_q <= nmisel_d;
  end

  assign nmisel = nmisel_q;
`else
  assign nmisel = 8'h00;
`endif

  always_comb begin
    enable_d = enable_q;
    edge_d   = edge_q;
    w1c      = 8'h00;
    if (wr_en) begin
      case (rs)
        IRQC_PEND:   w1c      = din & edge_q & SRC_MASK;
        IRQC_ENABLE: enable_d = din & SRC_MASK;
        IRQC_EDGE:   edge_d   = din & SRC_MASK;
        default: ;
      endcase
    end
  end

  // Edge bits latch (a new edge beats a same-cycle clear); level bits mirror the input.
  always_comb begin
    pend_d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (edge_q[i]) pend_d[i] = fall_v[i] | (pend_q[i] & ~w1c[i]);
      else           pend_d[i] = level_v[i];
    end
  end

  assign active = pend_q & enable_q;

  always_comb begin
    case (rs)
      IRQC_PEND:   rdata = pend_q;
      IRQC_ENABLE: rdata = enable_q;
      IRQC_EDGE:   rdata = edge_q;
      IRQC_VECTOR: rdata = irqc_vector(active);
      IRQC_RAW:    rdata = level_v;
      IRQC_NMISEL: rdata = nmisel;
      default:     rdata = 8'h00;
    endcase
  end

  assign dout_d  = rd_en ? rdata : dout_q;
  assign irq_n_d = ~|(active & ~nmisel);
  assign nmi_n_d = ~|(active & nmisel);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q   <= 8'h00;
      enable_q <= 8'h00;
      edge_q   <= 8'h00;
      dout_q   <= 8'h00;
      irq_n_q  <= 1'b1;
      nmi_n_q  <= 1'b1;
    end else begin
      pend_q   <= pend_d;
      enable_q <= enable_d;
      edge_q   <= edge_d;
      dout_q   <= dout_d;
      irq_n_q  <= irq_n_d;
      nmi_n_q  <= nmi_n_d;
    end
  end

  assign dout  = dout_q;
  assign irq_n = irq_n_q;
  assign nmi_n = nmi_n_q;

endmodule
